// File: rtl/fast_circle_compare_pkg.sv
// fast_pkg: shared definitions for the FAST segment-test front end.
// Holds the pixel/mask/score widths and types, and the Bresenham circle
// ordering that the window buffer and the arc detector also use. It also
// has the saturating helpers that build the hi/lo compare bounds.
// Optional feature macro used by the importing files: FAST_SCORE_EN.
package fast_pkg;

  localparam int PIX_W    = 8;
  localparam int N_CIRCLE = 16;
  localparam int SCORE_W  = 12;

  typedef logic [PIX_W-1:0]    pix_t;
  typedef logic [N_CIRCLE-1:0] mask_t;
  typedef logic [SCORE_W-1:0]  score_t;

  // Circle offsets (dx, dy) from the centre, indexed by mask bit.
  // k=0 is top and k increases clockwise, so bit 15 is next to bit 0.
  localparam int CIRCLE_DX [N_CIRCLE] = '{ 0,  1,  2,  3,  3, 3, 2, 1,
                                           0, -1, -2, -3, -3, -3, -2, -1};
  localparam int CIRCLE_DY [N_CIRCLE] = '{-3, -3, -2, -1,  0, 1, 2, 3,
                                           3,  3,  2,  1,  0, -1, -2, -3};

  // centre + threshold, saturated at the largest pixel value
  function automatic pix_t sat_hi(input pix_t center, input pix_t thr);
    logic [PIX_W:0] sum;
    sum = {1'b0, center} + {1'b0, thr};
    return sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
  endfunction

  // centre - threshold, saturated at zero
  function automatic pix_t sat_lo(input pix_t center, input pix_t thr);
    return (center > thr) ? pix_t'(center - thr) : '0;
  endfunction

endpackage

// File: rtl/fast_circle_compare_if.sv
// fast_circle_compare_if: candidate input and result output handshakes.
// Input side:  i_valid / o_ready carry i_center, i_circle, i_threshold.
// Output side: o_valid / i_ready carry o_bright, o_dark, o_score.
// i_circle holds circle pixel k at [PIX_W*k +: PIX_W].
// slave is the compare block's view and master is the producer/consumer view.
interface fast_circle_compare_if;
  import fast_pkg::*;

  logic                      i_valid;
  logic                      o_ready;
  pix_t                      i_center;
  logic [N_CIRCLE*PIX_W-1:0] i_circle;
  pix_t                      i_threshold;
  logic                      o_valid;
  logic                      i_ready;
  mask_t                     o_bright;
  mask_t                     o_dark;
  score_t                    o_score;

  modport slave (
    input  i_valid, i_center, i_circle, i_threshold, i_ready,
    output o_ready, o_valid, o_bright, o_dark, o_score
  );

  modport master (
    output i_valid, i_center, i_circle, i_threshold, i_ready,
    input  o_ready, o_valid, o_bright, o_dark, o_score
  );

endinterface

// File: rtl/fast_circle_compare_pix_cmp.sv
// fast_pix_cmp: combinational compare of one circle pixel against the
// saturated bounds.
//   p      : circle pixel
//   hi/lo  : centre+thr and centre-thr, both already clamped
//   bright : p > hi, strictly
//   dark   : p < lo, strictly
//   ex_b/d : how far p is past the bound, or 0 (only with FAST_SCORE_EN)
module fast_pix_cmp
  import fast_pkg::*;
(
  input  pix_t p,
  input  pix_t hi,
  input  pix_t lo,
  output logic bright,
  output logic dark
`ifdef FAST_SCORE_EN
  ,
  output pix_t ex_b,
  output pix_t ex_d
`endif
);

  assign bright = (p > hi);
  assign dark   = (p < lo);

`ifdef FAST_SCORE_EN
  assign ex_b = bright ? pix_t'(p - hi) : '0;
  assign ex_d = dark   ? pix_t'(lo - p) : '0;
`endif

endmodule

// File: rtl/fast_circle_compare.sv
// fast_circle_compare: 3-stage FAST segment-test front end.
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus (slave)  : candidate in (centre, 16 circle pixels, threshold) and
//                  result out (bright mask, dark mask, score)
// S1 registers the circle and the clamped hi/lo bounds. S2 registers the
// per-pixel masks and the excess values. S3 registers the outputs.
// All stages move together under one global enable.
// With FAST_SCORE_EN defined, the excess values and the adder trees are
// built. Without it, o_score is tied to 0.
module fast_circle_compare
  import fast_pkg::*;
(
  input logic                i_clk,
  input logic                i_rst,
  fast_circle_compare_if.slave bus
);

  logic                      en;
  logic                      s1_valid;
  logic [N_CIRCLE*PIX_W-1:0] s1_circle;
  pix_t                      s1_hi;
  pix_t                      s1_lo;
  mask_t                     cmp_bright;
  mask_t                     cmp_dark;
  logic                      s2_valid;
  mask_t                     s2_bright;
  mask_t                     s2_dark;
  logic                      out_valid;
  mask_t                     out_bright;
  mask_t                     out_dark;

  // A held result freezes every stage. Bubbles are kept, not squeezed out.
  assign en          = !out_valid || bus.i_ready;
  assign bus.o_ready = en;
  assign bus.o_valid = out_valid;
  assign bus.o_bright = out_bright;
  assign bus.o_dark   = out_dark;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_circle <= '0;
      s1_hi     <= '0;
      s1_lo     <= '0;
    end else if (en) begin
      s1_valid  <= bus.i_valid;
      s1_circle <= bus.i_circle;
      s1_hi     <= sat_hi(bus.i_center, bus.i_threshold);
      s1_lo     <= sat_lo(bus.i_center, bus.i_threshold);
    end
  end

`ifdef FAST_SCORE_EN
  pix_t   cmp_ex_b [N_CIRCLE];
  pix_t   cmp_ex_d [N_CIRCLE];
  pix_t   s2_ex_b  [N_CIRCLE];
  pix_t   s2_ex_d  [N_CIRCLE];
  score_t sum_b;
  score_t sum_d;
  score_t out_score;
`endif

  for (genvar k = 0; k < N_CIRCLE; k++) begin : g_cmp
    fast_pix_cmp u_cmp (
      .p      (s1_circle[PIX_W*k +: PIX_W]),
      .hi     (s1_hi),
      .lo     (s1_lo),
      .bright (cmp_bright[k]),
      .dark   (cmp_dark[k])
`ifdef FAST_SCORE_EN
      ,
      .ex_b   (cmp_ex_b[k]),
      .ex_d   (cmp_ex_d[k])
`endif
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid  <= 1'b0;
      s2_bright <= '0;
      s2_dark   <= '0;
`ifdef FAST_SCORE_EN
      for (int k = 0; k < N_CIRCLE; k++) begin
        s2_ex_b[k] <= '0;
        s2_ex_d[k] <= '0;
      end
`endif
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_bright <= cmp_bright;
      s2_dark   <= cmp_dark;
`ifdef FAST_SCORE_EN
      for (int k = 0; k < N_CIRCLE; k++) begin
        s2_ex_b[k] <= cmp_ex_b[k];
        s2_ex_d[k] <= cmp_ex_d[k];
      end
`endif
    end
  end

`ifdef FAST_SCORE_EN
  // 16 * (2^PIX_W - 1) fits in SCORE_W, so the sums cannot wrap.
  always_comb begin
    sum_b = '0;
    sum_d = '0;
    for (int k = 0; k < N_CIRCLE; k++) begin
      sum_b = sum_b + score_t'(s2_ex_b[k]);
      sum_d = sum_d + score_t'(s2_ex_d[k]);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      out_bright <= '0;
      out_dark   <= '0;
`ifdef FAST_SCORE_EN
      out_score  <= '0;
`endif
    end else if (en) begin
      out_valid  <= s2_valid;
      out_bright <= s2_bright;
      out_dark   <= s2_dark;
`ifdef FAST_SCORE_EN
      out_score  <= (sum_b > sum_d) ? sum_b : sum_d;
`endif
    end
  end

`ifdef FAST_SCORE_EN
  assign bus.o_score = out_score;
`else
  assign bus.o_score = '0;
`endif

endmodule

// File: doc/fast_circle_compare.md
# fast_circle_compare

Pipelined FAST segment-test front end for the ORB keypoint path. For each candidate it takes the centre pixel, its 16 Bresenham-circle neighbours and a threshold, and produces a 16-bit "brighter" mask and a 16-bit "darker" mask plus a corner score. The masks feed the contiguous-arc detector directly downstream: one instance checks `o_bright`, a second checks `o_dark`. It sits between the 7x7 window line-buffer and the arc detector / non-max suppression.

## Interface
- `PIX_W`, 8, pixel and threshold width.
- `SCORE_W`, 12, score width. Must be ≥ PIX_W+4.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: candidate present on inputs.
- `o_ready` out 1: block accepts the candidate this cycle.
- `i_center` in PIX_W: centre pixel.
- `i_circle` in 16*PIX_W: circle pixel k at [PIX_W*k +: PIX_W]. k=0 is top; k increases clockwise.
- `i_threshold` in PIX_W: FAST threshold, sampled with the candidate.
- `o_valid` out 1: result present.
- `i_ready` in 1: consumer takes the result this cycle.
- `o_bright` out 16: bit k = circle pixel k > centre+threshold.
- `o_dark` out 16: bit k = circle pixel k < centre−threshold.
- `o_score` out SCORE_W: corner score (see Configuration).

## Operation
- **Handshake:** the input transfer occurs when `i_valid && o_ready`. The output transfer occurs when `o_valid && i_ready`.
- **Stall:** global stall with `en = !o_valid || i_ready` and `o_ready = en`. All stages advance only when `en` is high. Bubbles are not collapsed.
- **S1:** register the circle pixels.
  - hi = min(center+thr, 2^PIX_W−1), computed in PIX_W+1 bits and then clamped.
  - lo = max(center−thr, 0).
  - The S1 valid bit is set from `i_valid`.
- **S2:** per pixel k:
  - bright_k = p_k > hi, strictly.
  - dark_k = p_k < lo, strictly.
  - ex_b_k = bright_k ? p_k−hi : 0.
  - ex_d_k = dark_k ? lo−p_k : 0.
  - Register the masks and the excesses.
- **S3:**
  - sum_b = Σex_b_k and sum_d = Σex_d_k, each unsigned SCORE_W, with no overflow possible (16·255 < 4096).
  - score = max(sum_b, sum_d).
  - Register the result into the outputs.
- **Clamping boundaries:**
  - hi saturates at 2^PIX_W−1, so no pixel can be bright.
  - lo saturates at 0, so no pixel can be dark.
- **thr = 0:** strict compare. Pixels equal to the centre set neither bit.
- **Mask properties:**
  - `o_bright & o_dark` is always 0.
  - The mask bit order matches the arc detector's wrap-around (bit 15 adjacent to bit 0).
- **Held outputs:** while `o_valid && !i_ready`, all outputs hold stable and nothing upstream moves.
- **Reset:**
  - All stage valid bits clear and all data registers clear to 0.
  - `o_valid`=0, `o_bright`=0, `o_dark`=0, `o_score`=0.
  - `o_ready`=1 in the first cycle after reset.
  - Inputs presented while `i_rst` is high are dropped.
  - Reset mid-stream flushes all in-flight candidates; nothing is emitted afterward.

## Timing
- Latency: 3 cycles from the accepting edge to `o_valid` with no stall.
- Throughput: 1 candidate/cycle while `i_ready`=1.
- `o_ready` is combinational from `i_ready` and `o_valid`. There is no other input-to-output combinational path.
- Stall: each cycle of `i_ready`=0 with `o_valid`=1 adds exactly 1 cycle to every in-flight candidate.

## Configuration
- `FAST_SCORE_EN` defined: the S2 excess registers and the S3 adder trees are built, and `o_score` is as specified above.
- `FAST_SCORE_EN` not defined:
  - The excess logic and adders are omitted.
  - `o_score` is tied to 0.
  - Masks, latency (3) and handshake are unchanged.

## Structure
- Shared package `fast_pkg`:
  - `PIX_W`, `N_CIRCLE`=16, `SCORE_W`.
  - typedefs `pix_t` (logic [PIX_W-1:0]), `mask_t` (logic [15:0]), `score_t`.
  - The circle index ordering constant, shared with the window buffer and the arc detector.
- Sub-module `fast_pix_cmp`:
  - Combinational per-pixel compare of p vs hi/lo, giving bright, dark, ex_b and ex_d.
  - Instantiated 16× in S2.
- The top level holds the S1–S3 registers, valids, stall enable and adder trees.

## Test plan
- **Reset:** hold `i_rst` 2 cycles with `i_valid`=1 and data → `o_valid`=0 and all outputs 0 during and after reset. No result appears.
- **Bright arc:** center=100, thr=10, pixels k=0..8 =120, others 100 → 3 cycles later `o_bright`=0x01FF, `o_dark`=0. With `FAST_SCORE_EN`, `o_score`=90.
- **Dark ring and equality:**
  - center=100, thr=10, all pixels 80 → `o_dark`=0xFFFF, `o_bright`=0, `o_score`=160.
  - Pixel=110 or 90 → its bit is 0 in both masks.
- **Saturation:**
  - center=250, thr=20, all 255 → `o_bright`=0.
  - center=10, thr=20, all 0 → `o_dark`=0.
  - Both give `o_score`=0.
- **Backpressure:** 6 back-to-back distinct candidates; drop `i_ready` for 3 cycles after the first output → `o_ready`=0 and outputs stable while stalled. All 6 results emerge in order, none lost or duplicated.
- **Reset mid-stream:** assert `i_rst` for 1 cycle with 2 candidates in flight → `o_valid`=0 the next cycle. The flushed candidates never appear, and a new candidate afterward returns in 3 cycles.
